aes_round_sequencer: RTL and testbench

Parametrised round sequencer for the AES datapath; the successor to the fixed 10-round counter. Supports AES-128/192/256 (Nr = 10/12/14) and encrypt or decrypt round ordering. Adds a start/busy/done handshake, stall, abort and invalid-key-length rejection. Drives round-key index selection and the MixColumns and final-round controls of the round datapath.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_round_sequencer.sv | 113 +++++++++++
 tb/tb_aes_round_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer: key-length encodings,
// round counts per key size, the sequencer state type and a helper that
// maps a key-length code to its round count.
package aes_pkg;

    localparam logic [1:0] KEY128  = 2'b00;
    localparam logic [1:0] KEY192  = 2'b01;
    localparam logic [1:0] KEY256  = 2'b10;
    localparam logic [1:0] KEY_INV = 2'b11;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } seq_state_t;

    // Standard AES round count for a key-length code; 0 flags an invalid code.
    function automatic int nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY128:  return NR_AES128;
            KEY192:  return NR_AES192;
            KEY256:  return NR_AES256;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Round sequencer for the AES datapath. Walks step 0..Nr for the selected
// key size, presents the round-key index in encrypt or decrypt order and
// decodes the MixColumns / last-round controls. Start/done handshake with
// stall (advance low), abort and rejection of the reserved key-length code.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int NR_128 = 10,
    parameter int NR_192 = 12,
    parameter int NR_256 = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic             decrypt,
    input  logic             advance,
    input  logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] step,
    output logic [CNT_W-1:0] round,
    output logic             mix_en,
    output logic             pre_final,
    output logic             final_round,
    output logic             done,
    output logic             key_err
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    seq_state_t       state;
    logic [CNT_W-1:0] step_r;
    logic [CNT_W-1:0] nr_lat;
    logic             dec_lat;
    logic             done_r;
    logic             key_err_r;

    // Round count for this instance's parameterisation of each key size.
    function automatic logic [CNT_W-1:0] nr_sel(input logic [1:0] kl);
        case (kl)
            KEY128:  return CNT_W'(NR_128);
            KEY192:  return CNT_W'(NR_192);
            KEY256:  return CNT_W'(NR_256);
            default: return '0;
        endcase
    endfunction

    // Sequencer state, step counter and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            step_r    <= '0;
            done_r    <= 1'b0;
            key_err_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            key_err_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (key_len == KEY_INV) begin
                            key_err_r <= 1'b1;
                        end else begin
                            state   <= S_RUN;
                            nr_lat  <= nr_sel(key_len);
                            dec_lat <= decrypt;
                            step_r  <= '0;
                        end
                    end
                end
                S_RUN: begin
                    // Abort wins over advance; step never passes Nr so no wrap.
                    if (abort) begin
                        state  <= S_IDLE;
                        step_r <= '0;
                    end else if (advance) begin
                        if (step_r == nr_lat) begin
                            state  <= S_IDLE;
                            step_r <= '0;
                            done_r <= 1'b1;
                        end else begin
                            step_r <= step_r + ONE;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    step_r <= '0;
                end
            endcase
        end
    end

    // Datapath controls decoded from registered state; all zero while idle.
    always_comb begin
        busy        = (state == S_RUN);
        step        = step_r;
        round       = '0;
        mix_en      = 1'b0;
        pre_final   = 1'b0;
        final_round = 1'b0;
        if (busy) begin
            round       = dec_lat ? (nr_lat - step_r) : step_r;
            mix_en      = (step_r != '0) && (step_r < nr_lat);
            pre_final   = (step_r == (nr_lat - ONE));
            final_round = (step_r == nr_lat);
        end
        done    = done_r;
        key_err = key_err_r;
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed scenarios with
// hand-computed expectations, then randomized control traffic, all checked
// every cycle against a behavioural model of the run/step/round rules.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, decrypt, advance, abort;
    logic [1:0] key_len;
    logic       busy, mix_en, pre_final, final_round, done, key_err;
    logic [3:0] step, round;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    // Behavioural model state
    bit m_busy = 0, m_dec = 0, m_done = 0, m_kerr = 0;
    int m_step = 0, m_nr = 0;

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len),
        .decrypt(decrypt), .advance(advance), .abort(abort),
        .busy(busy), .step(step), .round(round), .mix_en(mix_en),
        .pre_final(pre_final), .final_round(final_round),
        .done(done), .key_err(key_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a run holds Nr and direction, step counts 0..Nr on advance.
    always @(posedge clk) begin
        m_done <= 0;
        m_kerr <= 0;
        if (rst) begin
            m_busy <= 0;
            m_step <= 0;
        end else if (!m_busy) begin
            if (start) begin
                if (key_len == 2'b11) m_kerr <= 1;
                else begin
                    m_busy <= 1;
                    m_step <= 0;
                    m_nr   <= (key_len == 2'b00) ? 10 : (key_len == 2'b01) ? 12 : 14;
                    m_dec  <= decrypt;
                end
            end
        end else if (abort) begin
            m_busy <= 0;
            m_step <= 0;
        end else if (advance) begin
            if (m_step == m_nr) begin
                m_busy <= 0;
                m_step <= 0;
                m_done <= 1;
            end else m_step <= m_step + 1;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), int'(m_busy));
            chk("step", int'(step), m_busy ? m_step : 0);
            chk("round", int'(round), !m_busy ? 0 : (m_dec ? m_nr - m_step : m_step));
            chk("mix_en", int'(mix_en), int'(m_busy && m_step >= 1 && m_step <= m_nr - 1));
            chk("pre_final", int'(pre_final), int'(m_busy && m_step == m_nr - 1));
            chk("final_round", int'(final_round), int'(m_busy && m_step == m_nr));
            chk("done", int'(done), int'(m_done));
            chk("key_err", int'(key_err), int'(m_kerr));
        end
    end

    task automatic wait_step(input int s);
        int n = 0;
        while (!(busy && int'(step) == s) && n < 64) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 64) begin
            miscompares++;
            $display("FAIL wait_step: got step %0d expected %0d", step, s);
        end
    endtask

    // Launch a block at the current falling edge and follow it to the end.
    task automatic run_block(input logic [1:0] kl, input logic dc,
                             input int stall_step, input int stall_n,
                             output int cyc, output int r_first, output int r_last,
                             output int first_busy, output int done_seen);
        int st = 0;
        start = 1; key_len = kl; decrypt = dc; advance = 1; abort = 0;
        @(negedge clk);
        start = 0;
        cyc = 0; r_first = int'(round); r_last = -1; first_busy = int'(busy);
        while (busy && cyc < 100) begin
            cyc++;
            r_last = int'(round);
            if (int'(step) == stall_step && st < stall_n) begin
                advance = 0;
                st++;
            end else advance = 1;
            @(negedge clk);
        end
        done_seen = int'(done);
    endtask

    initial begin
        int cyc, rf, rl, fb, ds, n;
        rst = 1; start = 0; key_len = 0; decrypt = 0; advance = 0; abort = 0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset step", int'(step), 0);
        chk("reset done", int'(done), 0);
        rst = 0;
        @(negedge clk);

        // AES-128 encrypt, continuous advance
        run_block(2'b00, 1'b0, -1, 0, cyc, rf, rl, fb, ds);
        chk("enc128 busy cycles", cyc, 11);
        chk("enc128 first round", rf, 0);
        chk("enc128 last round", rl, 10);
        chk("enc128 done", ds, 1);

        // AES-256 decrypt, started in the done cycle: no bubble
        run_block(2'b10, 1'b1, -1, 0, cyc, rf, rl, fb, ds);
        chk("b2b busy immediately", fb, 1);
        chk("dec256 busy cycles", cyc, 15);
        chk("dec256 first round", rf, 14);
        chk("dec256 last round", rl, 0);
        chk("dec256 done", ds, 1);
        @(negedge clk);

        // AES-192 with a three-cycle stall at step 5
        run_block(2'b01, 1'b0, 5, 3, cyc, rf, rl, fb, ds);
        chk("stall192 busy cycles", cyc, 13 + 3);
        chk("stall192 done", ds, 1);
        @(negedge clk);

        // Abort at step 7 with advance high, then restart
        start = 1; key_len = 2'b00; decrypt = 0; advance = 1;
        @(negedge clk);
        start = 0;
        wait_step(7);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        start = 1; key_len = 2'b01;
        @(negedge clk);
        start = 0;
        chk("after abort busy", int'(busy), 1);
        chk("after abort step", int'(step), 0);
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);

        // Invalid key length rejected
        start = 1; key_len = 2'b11;
        @(negedge clk);
        start = 0;
        chk("key_err pulse", int'(key_err), 1);
        chk("key_err busy", int'(busy), 0);
        @(negedge clk);
        chk("key_err clears", int'(key_err), 0);

        // Abort in IDLE does not block start
        start = 1; abort = 1; key_len = 2'b10; decrypt = 1;
        @(negedge clk);
        start = 0; abort = 0;
        chk("idle abort start busy", int'(busy), 1);
        chk("idle abort start round", int'(round), 14);

        // Reset mid-run at step 4; start ignored while in reset
        wait_step(4);
        rst = 1; start = 1; key_len = 2'b00;
        @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst round", int'(round), 0);
        @(negedge clk);
        chk("rst start ignored", int'(busy), 0);
        rst = 0; start = 0;
        @(negedge clk);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            start   = ($urandom_range(0, 3) == 0);
            key_len = 2'($urandom_range(0, 3));
            decrypt = 1'($urandom_range(0, 1));
            advance = ($urandom_range(0, 3) != 0);
            abort   = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
